// File: rtl/scaled_sprite_engine.sv
// Paletted single-sprite renderer with integer scale, H/V flip, colour-key transparency and
// double-buffered position config. Optional frame animation is enabled with SPRITE_ANIM_EN.
module scaled_sprite_engine #(
  parameter int WIDTH     = 256,
  parameter int HEIGHT    = 256,
  parameter int PAL_DEPTH = 256,
  parameter int TRANS_IDX = 0,
  parameter int FRAMES    = 4,
  parameter int ANIM_DIV  = 8
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        new_frame_in,
  input  logic        cfg_we_in,
  input  logic [10:0] cfg_x_in,
  input  logic [9:0]  cfg_y_in,
  input  logic [1:0]  cfg_scale_in,
  input  logic        cfg_hflip_in,
  input  logic        cfg_vflip_in,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic        pixel_valid_out
);

  localparam int PAL_W = (PAL_DEPTH > 1) ? $clog2(PAL_DEPTH) : 1;
  localparam int U_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int V_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
`ifdef SPRITE_ANIM_EN
  localparam int NUM_FRAMES = FRAMES;
  localparam int FR_W       = (FRAMES > 1) ? $clog2(FRAMES) : 1;
`else
  // Single frame; the animation parameters only shape the animated build.
  localparam int NUM_FRAMES = (FRAMES > 0 && ANIM_DIV > 0) ? 1 : 1;
`endif
  localparam int ROM_DEPTH = NUM_FRAMES * WIDTH * HEIGHT;
  localparam int ADDR_W    = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

  // Texture ROM content: a fixed generated pattern folded from the texel address.
  function automatic logic [PAL_W-1:0] rom_lookup(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = 32'(a);
    return PAL_W'(w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]);
  endfunction

  function automatic logic [23:0] pal_lookup(input logic [PAL_W-1:0] i);
    logic [7:0] e;
    e = 8'(i);
    return {e, ~e, e[3:0], e[7:4]};
  endfunction

  logic [10:0] x_pend, x_act;
  logic [9:0]  y_pend, y_act;
  logic [1:0]  scale_pend, scale_act;
  logic        hflip_pend, hflip_act, vflip_pend, vflip_act;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x_pend     <= '0;
      y_pend     <= '0;
      scale_pend <= '0;
      hflip_pend <= 1'b0;
      vflip_pend <= 1'b0;
      x_act      <= '0;
      y_act      <= '0;
      scale_act  <= '0;
      hflip_act  <= 1'b0;
      vflip_act  <= 1'b0;
    end else begin
      // A write coinciding with the swap lands in pending only; active takes the old pending.
      if (new_frame_in) begin
        x_act     <= x_pend;
        y_act     <= y_pend;
        scale_act <= scale_pend;
        hflip_act <= hflip_pend;
        vflip_act <= vflip_pend;
      end
      if (cfg_we_in) begin
        x_pend     <= cfg_x_in;
        y_pend     <= cfg_y_in;
        scale_pend <= cfg_scale_in;
        hflip_pend <= cfg_hflip_in;
        vflip_pend <= cfg_vflip_in;
      end
    end
  end

`ifdef SPRITE_ANIM_EN
  logic [7:0]      div_cnt;
  logic [FR_W-1:0] frame_idx;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_cnt   <= '0;
      frame_idx <= '0;
    end else if (new_frame_in) begin
      if (div_cnt == 8'(ANIM_DIV - 1)) begin
        div_cnt   <= '0;
        frame_idx <= (frame_idx == FR_W'(FRAMES - 1)) ? '0 : frame_idx + FR_W'(1);
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end
`endif

  logic signed [13:0] dx, dy;
  int                 w_lim, h_lim, frame_base;
  logic [U_W-1:0]     u_raw, u_tex;
  logic [V_W-1:0]     v_raw, v_tex;
  logic               hit_next;
  logic [ADDR_W-1:0]  addr_next;

  always_comb begin
    dx = $signed({3'b000, hcount_in}) - $signed({3'b000, x_act});
    dy = $signed({4'b0000, vcount_in}) - $signed({4'b0000, y_act});
    w_lim = WIDTH << scale_act;
    h_lim = HEIGHT << scale_act;
    // Negative offsets are misses, so the sprite clips at the screen edges instead of wrapping.
    hit_next = (dx >= 0) && (int'(dx) < w_lim) && (dy >= 0) && (int'(dy) < h_lim);
    u_raw = U_W'($unsigned(dx) >> scale_act);
    v_raw = V_W'($unsigned(dy) >> scale_act);
    u_tex = hflip_act ? U_W'(WIDTH - 1) - u_raw : u_raw;
    v_tex = vflip_act ? V_W'(HEIGHT - 1) - v_raw : v_raw;
`ifdef SPRITE_ANIM_EN
    frame_base = int'(frame_idx) * WIDTH * HEIGHT;
`else
    frame_base = 0;
`endif
    addr_next = ADDR_W'(frame_base + int'(v_tex) * WIDTH + int'(u_tex));
  end

  logic [ADDR_W-1:0] addr_s1;
  logic [PAL_W-1:0]  img_q1, img_q2;
  logic [23:0]       pal_q1, pal_q2;
  logic              hit_s1, hit_s2, hit_s3, hit_s4, hit_s5;
  logic              trans_s4, trans_s5;

  // Memory data path; only the flags need reset so a flushed pipeline emits nothing.
  always_ff @(posedge pixel_clk_in) begin
    addr_s1 <= addr_next;
    img_q1  <= rom_lookup(addr_s1);
    img_q2  <= img_q1;
    pal_q1  <= pal_lookup(img_q2);
    pal_q2  <= pal_q1;
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hit_s1   <= 1'b0;
      hit_s2   <= 1'b0;
      hit_s3   <= 1'b0;
      hit_s4   <= 1'b0;
      hit_s5   <= 1'b0;
      trans_s4 <= 1'b0;
      trans_s5 <= 1'b0;
    end else begin
      hit_s1   <= hit_next;
      hit_s2   <= hit_s1;
      hit_s3   <= hit_s2;
      hit_s4   <= hit_s3;
      hit_s5   <= hit_s4;
      trans_s4 <= (img_q2 == PAL_W'(TRANS_IDX));
      trans_s5 <= trans_s4;
    end
  end

  assign pixel_valid_out = hit_s5 & ~trans_s5;
  assign red_out         = pixel_valid_out ? pal_q2[23:16] : 8'h00;
  assign green_out       = pixel_valid_out ? pal_q2[15:8]  : 8'h00;
  assign blue_out        = pixel_valid_out ? pal_q2[7:0]   : 8'h00;

endmodule
